// File: rtl/hdmi_stream_timing_gen.sv
// hdmi_stream_timing_gen: programmable HDMI raster generator that unpacks pixels
// from a show-ahead pixel FIFO.
// IDLE -> PRIME (latch the timing) -> RUN (raster) -> IDLE at a frame end once run_i is low.
// Optional build macro TEST_PATTERN_EN adds pattern_en_i, which selects 8 vertical
// colour bars in place of FIFO pixels.
module hdmi_stream_timing_gen #(
  parameter int          PIXEL_FIFO_DATA_WIDTH = 64,
  parameter int          BITS_PER_PIXEL        = 32,
  parameter int          CNT_W                 = 12,
  parameter logic [23:0] UNDERFLOW_RGB         = 24'hFF00FF
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             run_i,
`ifdef TEST_PATTERN_EN
  input  logic                             pattern_en_i,
`endif
  input  logic [CNT_W-1:0]                 cfg_h_total_i,
  input  logic [CNT_W-1:0]                 cfg_h_sync_i,
  input  logic [CNT_W-1:0]                 cfg_h_start_i,
  input  logic [CNT_W-1:0]                 cfg_h_end_i,
  input  logic [CNT_W-1:0]                 cfg_v_total_i,
  input  logic [CNT_W-1:0]                 cfg_v_sync_i,
  input  logic [CNT_W-1:0]                 cfg_v_start_i,
  input  logic [CNT_W-1:0]                 cfg_v_end_i,
  input  logic                             cfg_hs_pol_i,
  input  logic                             cfg_vs_pol_i,
  input  logic [PIXEL_FIFO_DATA_WIDTH-1:0] pixfifo_word_i,
  input  logic                             pixfifo_empty_i,
  output logic                             pixfifo_req_o,
  output logic [23:0]                      rgb_pixel_o,
  output logic                             hsync_o,
  output logic                             vsync_o,
  output logic                             data_enable_o,
  output logic                             frame_start_o,
  output logic                             underflow_o,
  output logic                             busy_o
);

  localparam int PPW    = PIXEL_FIFO_DATA_WIDTH / BITS_PER_PIXEL;
  localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PPW - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  if ((PIXEL_FIFO_DATA_WIDTH % BITS_PER_PIXEL) != 0) begin : g_bad_word_width
    $error("PIXEL_FIFO_DATA_WIDTH must be a multiple of BITS_PER_PIXEL");
  end
  if (BITS_PER_PIXEL < 24) begin : g_bad_pixel_width
    $error("BITS_PER_PIXEL must be at least 24");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    h_cnt_r;
  logic [CNT_W-1:0]    v_cnt_r;
  logic [SLOT_W-1:0]   slot_r;

  // Shadow timing: stable for a whole frame, reloaded only at the frame boundary.
  logic [CNT_W-1:0]    sh_h_total_r, sh_h_sync_r, sh_h_start_r, sh_h_end_r;
  logic [CNT_W-1:0]    sh_v_total_r, sh_v_sync_r, sh_v_start_r, sh_v_end_r;
  logic                sh_hs_pol_r, sh_vs_pol_r;

  logic                h_last_s, v_last_s, de_s, line_last_de_s;
  logic                pattern_s, fifo_pix_s, starve_s, take_s, pop_s;
  logic                load_shadow_s;
  logic [23:0]         pattern_rgb_s;
  logic [23:0]         rgb_s;

  // RGB of a slot: upper 24 bits of the slot, R in the MSBs.
  function automatic logic [23:0] slot_rgb(input logic [PIXEL_FIFO_DATA_WIDTH-1:0] word,
                                           input logic [SLOT_W-1:0]                slot);
    return word[int'(slot) * BITS_PER_PIXEL + BITS_PER_PIXEL - 1 -: 24];
  endfunction

`ifdef TEST_PATTERN_EN
  logic [CNT_W-1:0] bar_w_s;
  logic [CNT_W-1:0] bar_px_s;
  logic [2:0]       bar_idx_s;
  logic [CNT_W-1:0] bar_px_r;
  logic [2:0]       bar_idx_r;

  // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Bar position restarts at h_start; the stored counters carry it along the line.
  always_comb begin
    bar_w_s       = (sh_h_end_r - sh_h_start_r) >> 3;
    bar_px_s      = (h_cnt_r == sh_h_start_r) ? '0 : bar_px_r;
    bar_idx_s     = (h_cnt_r == sh_h_start_r) ? 3'd0 : bar_idx_r;
    pattern_s     = pattern_en_i;
    pattern_rgb_s = bar_color(bar_idx_s);
  end

  // Advance the bar pixel/index counters on active pattern pixels.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bar_px_r  <= '0;
      bar_idx_r <= 3'd0;
    end else if (de_s) begin
      if ((bar_w_s != '0) && (bar_px_s == bar_w_s - CNT_ONE)) begin
        bar_px_r  <= '0;
        bar_idx_r <= (bar_idx_s == 3'd7) ? 3'd7 : bar_idx_s + 3'd1;
      end else begin
        bar_px_r  <= bar_px_s + CNT_ONE;
        bar_idx_r <= bar_idx_s;
      end
    end
  end
`else
  // Without the pattern generator all active pixels come from the FIFO.
  always_comb begin
    pattern_s     = 1'b0;
    pattern_rgb_s = 24'h000000;
  end
`endif

  // Raster decode, FIFO pop decision and pixel selection for the current counter state.
  always_comb begin
    h_last_s       = (h_cnt_r == sh_h_total_r);
    v_last_s       = (v_cnt_r == sh_v_total_r);
    de_s           = (state_r == ST_RUN) &&
                     (h_cnt_r >= sh_h_start_r) && (h_cnt_r < sh_h_end_r) &&
                     (v_cnt_r >= sh_v_start_r) && (v_cnt_r < sh_v_end_r);
    line_last_de_s = de_s && (h_cnt_r == sh_h_end_r - CNT_ONE);
    fifo_pix_s     = de_s && !pattern_s;
    starve_s       = fifo_pix_s && pixfifo_empty_i;
    take_s         = fifo_pix_s && !pixfifo_empty_i;
    // A partial word at line end is popped and dropped so each line starts word-aligned.
    pop_s          = take_s && ((slot_r == LAST_SLOT) || line_last_de_s);
    load_shadow_s  = (state_r == ST_PRIME) ||
                     ((state_r == ST_RUN) && h_last_s && v_last_s && run_i);
    if (!de_s) begin
      rgb_s = 24'h000000;
    end else if (pattern_s) begin
      rgb_s = pattern_rgb_s;
    end else if (starve_s) begin
      rgb_s = UNDERFLOW_RGB;
    end else begin
      rgb_s = slot_rgb(pixfifo_word_i, slot_r);
    end
  end

  // The pop is issued in the cycle the slot is consumed so the show-ahead head is fresh next cycle.
  assign pixfifo_req_o = pop_s;

  // Shadow timing capture while priming and at each continuing frame wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_h_total_r <= '0; sh_h_sync_r <= '0; sh_h_start_r <= '0; sh_h_end_r <= '0;
      sh_v_total_r <= '0; sh_v_sync_r <= '0; sh_v_start_r <= '0; sh_v_end_r <= '0;
      sh_hs_pol_r  <= 1'b0;
      sh_vs_pol_r  <= 1'b0;
    end else if (load_shadow_s) begin
      sh_h_total_r <= cfg_h_total_i; sh_h_sync_r <= cfg_h_sync_i;
      sh_h_start_r <= cfg_h_start_i; sh_h_end_r  <= cfg_h_end_i;
      sh_v_total_r <= cfg_v_total_i; sh_v_sync_r <= cfg_v_sync_i;
      sh_v_start_r <= cfg_v_start_i; sh_v_end_r  <= cfg_v_end_i;
      sh_hs_pol_r  <= cfg_hs_pol_i;
      sh_vs_pol_r  <= cfg_vs_pol_i;
    end
  end

  // Sequencer FSM with raster counters, slot tracking and registered video outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= ST_IDLE;
      h_cnt_r       <= '0;
      v_cnt_r       <= '0;
      slot_r        <= '0;
      rgb_pixel_o   <= 24'h000000;
      hsync_o       <= 1'b0;
      vsync_o       <= 1'b0;
      data_enable_o <= 1'b0;
      frame_start_o <= 1'b0;
      underflow_o   <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      // Outside RUN the video outputs rest blank with syncs inactive.
      rgb_pixel_o   <= 24'h000000;
      data_enable_o <= 1'b0;
      frame_start_o <= 1'b0;
      hsync_o       <= ~cfg_hs_pol_i;
      vsync_o       <= ~cfg_vs_pol_i;
      case (state_r)
        ST_IDLE: begin
          h_cnt_r     <= '0;
          v_cnt_r     <= '0;
          slot_r      <= '0;
          underflow_o <= 1'b0;
          if (run_i) begin
            state_r <= ST_PRIME;
            busy_o  <= 1'b1;
          end else begin
            busy_o  <= 1'b0;
          end
        end
        ST_PRIME: begin
          h_cnt_r <= '0;
          v_cnt_r <= '0;
          slot_r  <= '0;
          if (!run_i) begin
            state_r <= ST_IDLE;
            busy_o  <= 1'b0;
          end else if (!pixfifo_empty_i) begin
            state_r <= ST_RUN;
            busy_o  <= 1'b1;
          end else begin
            busy_o  <= 1'b1;
          end
        end
        ST_RUN: begin
          rgb_pixel_o   <= rgb_s;
          data_enable_o <= de_s;
          frame_start_o <= (h_cnt_r == '0) && (v_cnt_r == '0);
          hsync_o       <= (h_cnt_r < sh_h_sync_r) ? sh_hs_pol_r : ~sh_hs_pol_r;
          vsync_o       <= (v_cnt_r < sh_v_sync_r) ? sh_vs_pol_r : ~sh_vs_pol_r;
          if (starve_s) begin
            underflow_o <= 1'b1;
          end
          if (h_last_s || pop_s) begin
            slot_r <= '0;
          end else if (take_s) begin
            slot_r <= slot_r + SLOT_ONE;
          end
          busy_o <= 1'b1;
          if (h_last_s) begin
            h_cnt_r <= '0;
            if (v_last_s) begin
              v_cnt_r <= '0;
              if (!run_i) begin
                state_r <= ST_IDLE;
                busy_o  <= 1'b0;
              end
            end else begin
              v_cnt_r <= v_cnt_r + CNT_ONE;
            end
          end else begin
            h_cnt_r <= h_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          h_cnt_r <= '0;
          v_cnt_r <= '0;
          slot_r  <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_stream_timing_gen.sv
// Directed bench for hdmi_stream_timing_gen: 10x6 raster, 4x2 active, 2 pixels/word,
// show-ahead FIFO modelled by the bench itself.
module tb_hdmi_stream_timing_gen;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        run_i;
  logic [11:0] cfg_h_total, cfg_h_sync, cfg_h_start, cfg_h_end;
  logic [11:0] cfg_v_total, cfg_v_sync, cfg_v_start, cfg_v_end;
  logic        cfg_hs_pol, cfg_vs_pol;
  logic [63:0] pixfifo_word;
  logic        pixfifo_empty;
  logic        pixfifo_req;
  logic [23:0] rgb_pixel;
  logic        hsync, vsync, data_enable, frame_start, underflow, busy;

  hdmi_stream_timing_gen dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .run_i           (run_i),
    .cfg_h_total_i   (cfg_h_total),
    .cfg_h_sync_i    (cfg_h_sync),
    .cfg_h_start_i   (cfg_h_start),
    .cfg_h_end_i     (cfg_h_end),
    .cfg_v_total_i   (cfg_v_total),
    .cfg_v_sync_i    (cfg_v_sync),
    .cfg_v_start_i   (cfg_v_start),
    .cfg_v_end_i     (cfg_v_end),
    .cfg_hs_pol_i    (cfg_hs_pol),
    .cfg_vs_pol_i    (cfg_vs_pol),
    .pixfifo_word_i  (pixfifo_word),
    .pixfifo_empty_i (pixfifo_empty),
    .pixfifo_req_o   (pixfifo_req),
    .rgb_pixel_o     (rgb_pixel),
    .hsync_o         (hsync),
    .vsync_o         (vsync),
    .data_enable_o   (data_enable),
    .frame_start_o   (frame_start),
    .underflow_o     (underflow),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model
  logic [63:0] fifo_mem [0:3];
  int          rd_ptr  = 0;
  int          n_words = 0;
  logic        req_seen = 1'b0;
  logic        prev_req = 1'b0;

  // Per-frame statistics
  int          de_cnt, hs_cnt, vs_cnt, fs_cnt, pop_cnt, offde_nz;
  logic [31:0] pop_mask;
  logic [23:0] rgb_q [$];
  logic        busy_log [0:63];
  logic        uf_log   [0:63];

  logic [23:0] exp_f1 [0:7] = '{24'hAABBCC, 24'h001122, 24'h8899AA, 24'h445566,
                                24'hCCDDEE, 24'hDDEEFF, 24'hF0F0F0, 24'h0F0F0F};
  logic [23:0] exp_f3 [0:5] = '{24'hAABBCC, 24'h001122, 24'h8899AA,
                                24'hCCDDEE, 24'hDDEEFF, 24'hF0F0F0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo();
    pixfifo_empty = (rd_ptr >= n_words);
    pixfifo_word  = pixfifo_empty ? 64'd0 : fifo_mem[rd_ptr];
  endtask

  task automatic load_fifo();
    fifo_mem[0] = 64'h00112233_AABBCC00;
    fifo_mem[1] = 64'h44556677_8899AABB;
    fifo_mem[2] = 64'hDDEEFF00_CCDDEEFF;
    fifo_mem[3] = 64'h0F0F0F0F_F0F0F0F0;
    rd_ptr  = 0;
    n_words = 4;
    update_fifo();
  endtask

  // One clock: apply the pop seen in the last cycle, then sample at the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (req_seen && (rd_ptr < n_words)) rd_ptr++;
    update_fifo();
    @(negedge clk);
    prev_req = req_seen;
    req_seen = pixfifo_req;
  endtask

  task automatic wait_fs(input string tag);
    int guard = 0;
    while ((frame_start !== 1'b1) && (guard < 300)) begin
      cycle();
      guard++;
    end
    chk(tag, {31'd0, frame_start}, 32'd1);
  endtask

  task automatic collect(input int n, input int drop_at, input int cfg_at);
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; pop_cnt = 0; offde_nz = 0;
    pop_mask = 32'd0;
    rgb_q.delete();
    for (int j = 0; j < n; j++) begin
      if (data_enable) begin
        if (prev_req && (de_cnt < 32)) pop_mask[de_cnt] = 1'b1;
        rgb_q.push_back(rgb_pixel);
        de_cnt++;
      end else if (rgb_pixel != 24'd0) begin
        offde_nz++;
      end
      hs_cnt  += int'(hsync);
      vs_cnt  += int'(vsync);
      fs_cnt  += int'(frame_start);
      pop_cnt += int'(req_seen);
      if (j < 64) begin
        busy_log[j] = busy;
        uf_log[j]   = underflow;
      end
      if (j == drop_at) run_i = 1'b0;
      if (j == cfg_at) begin
        cfg_h_end  = 12'd7;
        cfg_v_sync = 12'd2;
      end
      cycle();
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    run_i  = 1'b0;
    cfg_h_total = 12'd9; cfg_h_sync = 12'd1; cfg_h_start = 12'd3; cfg_h_end = 12'd7;
    cfg_v_total = 12'd5; cfg_v_sync = 12'd1; cfg_v_start = 12'd2; cfg_v_end = 12'd4;
    cfg_hs_pol = 1'b1;
    cfg_vs_pol = 1'b1;
    update_fifo();
    @(negedge clk);
    @(negedge clk);
    chk("reset_rgb", {8'd0, rgb_pixel}, 32'd0);
    chk("reset_ctrl", {25'd0, hsync, vsync, data_enable, frame_start, underflow, busy, pixfifo_req}, 32'd0);

    // PRIME waits on an empty FIFO and falls back to IDLE when run drops
    rst_ni = 1'b1;
    run_i  = 1'b1;
    cycle(); cycle(); cycle();
    chk("prime_busy", {31'd0, busy}, 32'd1);
    chk("prime_de", {31'd0, data_enable}, 32'd0);
    run_i = 1'b0;
    cycle(); cycle();
    chk("prime_abort_busy", {31'd0, busy}, 32'd0);

    // Frame 1: full FIFO, 8 pixels, pops on every second pixel
    load_fifo();
    run_i = 1'b1;
    wait_fs("f1_start");
    collect(60, -1, -1);
    chk("f1_de_cnt", de_cnt, 32'd8);
    chk("f1_hs_cnt", hs_cnt, 32'd6);
    chk("f1_vs_cnt", vs_cnt, 32'd10);
    chk("f1_fs_cnt", fs_cnt, 32'd1);
    chk("f1_pop_cnt", pop_cnt, 32'd4);
    chk("f1_pop_mask", pop_mask, 32'hAA);
    chk("f1_offde_rgb", offde_nz, 32'd0);
    chk("f1_underflow", {31'd0, uf_log[59]}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i < rgb_q.size()) chk($sformatf("f1_rgb%0d", i), {8'd0, rgb_q[i]}, {8'd0, exp_f1[i]});
    end
    chk("f2_fs_period", {31'd0, frame_start}, 32'd1);
    chk("f2_hsync_start", {31'd0, hsync}, 32'd1);

    // Frame 2: FIFO empty -> underflow colour, run dropped mid-frame
    collect(60, 30, -1);
    chk("f2_de_cnt", de_cnt, 32'd8);
    chk("f2_hs_cnt", hs_cnt, 32'd6);
    chk("f2_vs_cnt", vs_cnt, 32'd10);
    chk("f2_pop_cnt", pop_cnt, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i < rgb_q.size()) chk($sformatf("f2_rgb%0d", i), {8'd0, rgb_q[i]}, 32'h00FF00FF);
    end
    chk("f2_uf_before", {31'd0, uf_log[22]}, 32'd0);
    chk("f2_uf_set", {31'd0, uf_log[23]}, 32'd1);
    chk("f2_uf_held", {31'd0, uf_log[59]}, 32'd1);
    chk("f2_busy_58", {31'd0, busy_log[58]}, 32'd1);
    chk("f2_busy_59", {31'd0, busy_log[59]}, 32'd0);
    chk("idle_uf_clear", {31'd0, underflow}, 32'd0);
    chk("idle_fs", {31'd0, frame_start}, 32'd0);

    // Frame 3: active width 3, cfg changed mid-frame
    cfg_h_end = 12'd6;
    load_fifo();
    run_i = 1'b1;
    wait_fs("f3_start");
    collect(60, -1, 30);
    chk("f3_de_cnt", de_cnt, 32'd6);
    chk("f3_vs_cnt", vs_cnt, 32'd10);
    chk("f3_pop_cnt", pop_cnt, 32'd4);
    chk("f3_pop_mask", pop_mask, 32'h36);
    for (int i = 0; i < 6; i++) begin
      if (i < rgb_q.size()) chk($sformatf("f3_rgb%0d", i), {8'd0, rgb_q[i]}, {8'd0, exp_f3[i]});
    end
    chk("f4_fs_period", {31'd0, frame_start}, 32'd1);

    // Frame 4: new cfg (width 4, vsync 2 lines) in effect
    collect(60, -1, -1);
    chk("f4_de_cnt", de_cnt, 32'd8);
    chk("f4_vs_cnt", vs_cnt, 32'd20);
    chk("f4_hs_cnt", hs_cnt, 32'd6);
    chk("f5_fs_period", {31'd0, frame_start}, 32'd1);

    // Frame 5: async reset mid-line
    for (int i = 0; i < 24; i++) cycle();
    chk("f5_de_midline", {31'd0, data_enable}, 32'd1);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_rgb", {8'd0, rgb_pixel}, 32'd0);
    chk("rst_mid_ctrl", {25'd0, hsync, vsync, data_enable, frame_start, underflow, busy, pixfifo_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
